// File: rtl/idct_block_arbiter.sv
// idct_block_arbiter: shares one row-serial 8x8 IDCT core between N_REQ requester
// streams. A requester is granted round-robin for a whole block. Its 8 rows are
// fed to the core, then the core's 8 result rows are forwarded downstream,
// tagged with the owning requester ID and a last-row flag.
module idct_block_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIN   = 12,
    parameter int unsigned WOUT  = 9,
    parameter int unsigned IDW   = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ*8*WIN-1:0] s_tdata,
    input  logic [N_REQ-1:0]       s_tvalid,
    output logic [N_REQ-1:0]       s_tready,
    output logic [8*WIN-1:0]       core_tdata,
    output logic                   core_tvalid,
    input  logic                   core_tready,
    input  logic [8*WOUT-1:0]      core_rdata,
    input  logic                   core_rvalid,
    output logic                   core_rready,
    output logic [8*WOUT-1:0]      m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [IDW-1:0]         m_tid,
    output logic                   m_tlast,
    output logic                   busy,
    output logic [15:0]            blk_count
);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [2:0]     in_cnt_q, in_cnt_d;
    logic [2:0]     out_cnt_q, out_cnt_d;
    logic [15:0]    blk_count_q, blk_count_d;

    logic [8*WIN-1:0] s_rows [N_REQ];
    logic             arb_found;
    logic [IDW-1:0]   arb_pick;
    logic [IDW-1:0]   scan_idx;

    // (base + off) mod N_REQ; both operands are already below N_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDW'(sum);
    endfunction

    // Split the flat requester bus into one row per requester.
    always_comb begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
            s_rows[r] = s_tdata[r*8*WIN +: 8*WIN];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = wrap_add(rr_ptr_q, i);
            if (!arb_found && s_tvalid[scan_idx]) begin
                arb_found = 1'b1;
                arb_pick  = scan_idx;
            end
        end
    end

    // Next-state logic and the pass-through handshake muxing.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        blk_count_d = blk_count_q;
        s_tready    = '0;
        core_tvalid = 1'b0;
        core_tdata  = '0;
        core_rready = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tlast     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant_d  = arb_pick;
                    rr_ptr_d = wrap_add(arb_pick, 1);
                    state_d  = StFeed;
                end
            end
            StFeed: begin
                // Grant is held for the whole block, even across s_tvalid gaps.
                core_tvalid        = s_tvalid[grant_q];
                core_tdata         = s_rows[grant_q];
                s_tready[grant_q]  = core_tready;
                if (core_tvalid && core_tready) begin
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                m_tvalid    = core_rvalid;
                m_tdata     = core_rdata;
                core_rready = m_tready;
                m_tlast     = (out_cnt_q == 3'd7);
                if (m_tvalid && m_tready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d     = StIdle;
                        blk_count_d = blk_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign m_tid     = grant_q;
    assign busy      = (state_q != StIdle);
    assign blk_count = blk_count_q;

endmodule
